mips_fetch_queue: RTL

Instruction prefetch unit that sits directly upstream of the pipelined MIPS32 core's IF/ID latch. It issues word reads to instruction memory over a pipelined request/response port and keeps up to DEPTH requests in flight. Returned words are buffered in an in-order FIFO and presented to the core as {IR, NPC} pairs over a valid/ready handshake. A branch redirect flushes the buffer, discards responses still in flight and restarts fetch at the target.

---
 rtl/mips_fetch_queue.sv | 104 ++++++++++
 1 files changed

// File: rtl/mips_fetch_queue.sv
// rtl/mips_fetch_queue.sv - instruction prefetch queue feeding the MIPS32 IF/ID latch
module mips_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_ack,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     halt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_ir,
    output logic [31:0]              out_npc,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   ir_q  [DEPTH];
    logic [31:0]   npc_q [DEPTH];
    logic [31:0]   sh_q  [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, sh_rd, sh_wr;
    logic [LW-1:0] inflight, drop_cnt, inflight_nxt;
    logic [LW:0]   credit_sum;
    logic          active;
    logic          accept, fifo_wr, fifo_rd;

    // active keeps mem_req low while reset is held, without a combinational path from rst_n
    assign credit_sum   = {1'b0, level} + {1'b0, inflight};
    assign mem_req      = active && !halt && (credit_sum < (LW+1)'(DEPTH));
    assign mem_addr     = fetch_pc[ADDR_W-1:0];
    assign accept       = mem_req && mem_ack;
    assign inflight_nxt = inflight + LW'(accept) - LW'(mem_rvalid);
    assign fifo_wr      = mem_rvalid && (drop_cnt == '0) && !redirect;
    assign fifo_rd      = out_valid && out_ready;
    assign out_valid    = (level != '0);
    assign out_ir       = out_valid ? ir_q[rd_ptr]  : 32'd0;
    assign out_npc      = out_valid ? npc_q[rd_ptr] : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            fetch_pc <= RESET_PC;
            sh_wr    <= '0;
            sh_rd    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            active   <= 1'b1;
            inflight <= inflight_nxt;
            if (redirect)
                fetch_pc <= redirect_pc;
            else if (accept)
                fetch_pc <= fetch_pc + 32'd1;
            if (accept)
                sh_wr <= sh_wr + 1'b1;
            if (mem_rvalid)
                sh_rd <= sh_rd + 1'b1;
            // everything still outstanding after this edge belongs to the old stream
            if (redirect)
                drop_cnt <= inflight_nxt;
            else if (mem_rvalid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (fifo_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(fifo_wr) - LW'(fifo_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            sh_q[sh_wr] <= fetch_pc;
        if (fifo_wr) begin
            ir_q[wr_ptr]  <= mem_rdata;
            npc_q[wr_ptr] <= sh_q[sh_rd] + 32'd1;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) mem_rvalid |-> inflight != '0);

endmodule
